// File: rtl/ioctl_loader.sv
// ioctl_loader: steers MiSTer ioctl downloads into ROM writes, SYSMODE and DIP storage, and sequences core reset.
// Optional feature macro LOADER_CHECKSUM_EN adds an additive 8-bit checksum of ROM bytes on rom_csum.
module ioctl_loader #(
    parameter int unsigned ROM_INDEX  = 0,
    parameter int unsigned MODE_INDEX = 1,
    parameter int unsigned DSW_INDEX  = 254,
    parameter int unsigned POST_HOLD  = 256
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic        rom_we,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [7:0]  sysmode,
    output logic [63:0] dsw,
    output logic        core_reset,
    output logic        load_done,
    output logic [24:0] rom_bytes,
    output logic [7:0]  rom_csum
);

    localparam int CW = $clog2(POST_HOLD + 1);
    localparam logic [CW-1:0] HOLD_INIT = CW'(POST_HOLD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          core_reset_q;
    logic          load_done_q;

    logic          dl_q;
    logic          rom_we_q;
    logic [24:0]   rom_addr_q;
    logic [7:0]    rom_data_q;
    logic [7:0]    sysmode_q, sysmode_d;
    logic [63:0]   dsw_q, dsw_d;
    logic [24:0]   rom_bytes_q, rom_bytes_d;

    logic sel_rom, sel_mode, sel_dsw;
    logic wr_en, rom_wr, rom_start, dl_fall, hold_last, count_wr;

    assign sel_rom   = (ioctl_index == 8'(ROM_INDEX));
    assign sel_mode  = (ioctl_index == 8'(MODE_INDEX));
    assign sel_dsw   = (ioctl_index == 8'(DSW_INDEX));
    assign wr_en     = ioctl_wr & ioctl_download;
    assign rom_wr    = wr_en & sel_rom;
    assign rom_start = ioctl_download & ~dl_q & sel_rom;
    assign dl_fall   = ~ioctl_download & dl_q;
    assign hold_last = (cnt_q == CW'(1)) || (cnt_q == '0);
    // Writes only accumulate inside LOAD; the starting edge is handled separately so a coincident byte counts.
    assign count_wr  = (state_q == S_LOAD) & rom_wr;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            if (rom_start) begin
                state_q      <= S_LOAD;
                cnt_q        <= '0;
                core_reset_q <= 1'b1;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (dl_fall) begin
                            state_q <= S_HOLD;
                            cnt_q   <= HOLD_INIT;
                        end
                    end
                    S_HOLD: begin
                        if (user_reset) begin
                            cnt_q <= HOLD_INIT;
                        end else if (hold_last) begin
                            state_q      <= S_RUN;
                            cnt_q        <= '0;
                            core_reset_q <= 1'b0;
                            load_done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_RUN: begin
                        if (user_reset) begin
                            state_q      <= S_HOLD;
                            cnt_q        <= HOLD_INIT;
                            core_reset_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        rom_bytes_d = rom_bytes_q;
        if (rom_start) begin
            rom_bytes_d = {24'd0, rom_wr};
        end else if (count_wr && !(&rom_bytes_q)) begin
            rom_bytes_d = rom_bytes_q + 25'd1;
        end

        sysmode_d = sysmode_q;
        if (wr_en && sel_mode && (ioctl_addr == 25'd0)) begin
            sysmode_d = ioctl_dout;
        end

        dsw_d = dsw_q;
        if (wr_en && sel_dsw && (ioctl_addr[24:3] == 22'd0)) begin
            dsw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q        <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_data_q  <= '0;
            sysmode_q   <= 8'h00;
            dsw_q       <= '1;
            rom_bytes_q <= '0;
        end else begin
            dl_q     <= ioctl_download;
            rom_we_q <= rom_wr;
            if (rom_wr) begin
                rom_addr_q <= ioctl_addr;
                rom_data_q <= ioctl_dout;
            end
            sysmode_q   <= sysmode_d;
            dsw_q       <= dsw_d;
            rom_bytes_q <= rom_bytes_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (rom_start) begin
            csum_d = rom_wr ? ioctl_dout : 8'h00;
        end else if (count_wr) begin
            csum_d = csum_q + ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign rom_csum = csum_q;
`else
    assign rom_csum = 8'h00;
`endif

    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign sysmode    = sysmode_q;
    assign dsw        = dsw_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign rom_bytes  = rom_bytes_q;

endmodule

// File: tb/tb_ioctl_loader.sv
// Testbench for ioctl_loader: vector table, directed corner sequences and randomized traffic against a deadline-based model.
module tb_ioctl_loader;

    localparam int PH = 4;
    localparam int MAXB = 33554431;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_HOLD = 2;
    localparam int P_RUN  = 3;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        user_reset = 1'b0;
    logic        rom_we;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  sysmode;
    logic [63:0] dsw;
    logic        core_reset;
    logic        load_done;
    logic [24:0] rom_bytes;
    logic [7:0]  rom_csum;

    always #5 clk_sys = ~clk_sys;

    ioctl_loader #(
        .ROM_INDEX (0),
        .MODE_INDEX(1),
        .DSW_INDEX (254),
        .POST_HOLD (PH)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_index   (ioctl_index),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .user_reset    (user_reset),
        .rom_we        (rom_we),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .sysmode       (sysmode),
        .dsw           (dsw),
        .core_reset    (core_reset),
        .load_done     (load_done),
        .rom_bytes     (rom_bytes),
        .rom_csum      (rom_csum)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_seen = 0;

    // Reference model: phase plus a release deadline expressed in edge numbers.
    int          m_phase;
    int          m_release_at;
    bit          m_dlprev;
    logic        m_we;
    logic [24:0] m_addr;
    logic [7:0]  m_data;
    logic [7:0]  m_sysmode;
    logic [63:0] m_dsw;
    logic        m_done;
    int          m_bytes;
    int          m_sum;

    typedef struct {
        logic        dl;
        logic        wr;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        ur;
        logic        e_we;
        logic [24:0] e_addr;
        logic [7:0]  e_data;
        logic        e_cr;
        logic        e_done;
        logic [24:0] e_bytes;
        logic [7:0]  e_csum;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mkv(input logic dl, input logic wr, input logic [7:0] idx,
                                 input logic [24:0] addr, input logic [7:0] dout, input logic ur,
                                 input logic e_we, input logic [24:0] e_addr, input logic [7:0] e_data,
                                 input logic e_cr, input logic e_done, input logic [24:0] e_bytes,
                                 input logic [7:0] e_csum);
        vec_t v;
        v.dl = dl; v.wr = wr; v.idx = idx; v.addr = addr; v.dout = dout; v.ur = ur;
        v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data; v.e_cr = e_cr;
        v.e_done = e_done; v.e_bytes = e_bytes; v.e_csum = e_csum;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_release_at = 0;
        m_dlprev = 1'b0;
        m_we = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_sysmode = 8'h00;
        m_dsw = '1;
        m_done = 1'b0;
        m_bytes = 0;
        m_sum = 0;
    endtask

    task automatic model_edge();
        bit rise, fall, wr_any, wr_rom;
        rise   = ioctl_download && !m_dlprev;
        fall   = !ioctl_download && m_dlprev;
        wr_any = ioctl_wr && ioctl_download;
        wr_rom = wr_any && (ioctl_index == 8'd0);
        m_we = wr_rom;
        if (wr_rom) begin
            m_addr = ioctl_addr;
            m_data = ioctl_dout;
        end
        if (wr_any && ioctl_index == 8'd1 && ioctl_addr == 25'd0) m_sysmode = ioctl_dout;
        if (wr_any && ioctl_index == 8'd254 && ioctl_addr < 25'd8) m_dsw[int'(ioctl_addr) * 8 +: 8] = ioctl_dout;
        m_done = 1'b0;
        if (rise && ioctl_index == 8'd0) begin
            m_phase = P_LOAD;
            m_bytes = wr_rom ? 1 : 0;
            m_sum   = wr_rom ? int'(ioctl_dout) : 0;
        end else if (m_phase == P_LOAD) begin
            if (wr_rom) begin
                if (m_bytes != MAXB) m_bytes = m_bytes + 1;
                m_sum = (m_sum + int'(ioctl_dout)) % 256;
            end
            if (fall) begin
                m_phase = P_HOLD;
                m_release_at = cyc + PH;
            end
        end else if (m_phase == P_HOLD) begin
            if (user_reset) m_release_at = cyc + PH;
            else if (cyc >= m_release_at) begin
                m_phase = P_RUN;
                m_done = 1'b1;
            end
        end else if (m_phase == P_RUN && user_reset) begin
            m_phase = P_HOLD;
            m_release_at = cyc + PH;
        end
        m_dlprev = ioctl_download;
    endtask

    task automatic compare_model();
        logic [140:0] got, exp;
        logic [7:0]   ecs;
        ecs = CSUM_EN ? m_sum[7:0] : 8'h00;
        exp = {m_we, m_addr, m_data, m_sysmode, m_dsw, (m_phase != P_RUN), m_done, m_bytes[24:0], ecs};
        got = {rom_we, rom_addr, rom_data, sysmode, dsw, core_reset, load_done, rom_bytes, rom_csum};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL model cyc=%0d got=%h exp=%h", cyc, got, exp);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        cyc++;
        model_edge();
        @(negedge clk_sys);
        if (load_done) done_seen++;
        compare_model();
    endtask

    task automatic set_in(input logic dl, input logic wr, input logic [7:0] idx,
                          input logic [24:0] addr, input logic [7:0] dout);
        ioctl_download = dl;
        ioctl_wr = wr;
        ioctl_index = idx;
        ioctl_addr = addr;
        ioctl_dout = dout;
    endtask

    function automatic logic [7:0] pick_idx();
        case ($urandom_range(0, 3))
            0: return 8'd0;
            1: return 8'd1;
            2: return 8'd254;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        logic [7:0] ecs;

        tbl[0]  = mkv(1, 0, 8'd0, 25'd0, 8'h00, 0,  0, 25'd0, 8'h00, 1, 0, 25'd0, 8'h00);
        tbl[1]  = mkv(1, 1, 8'd0, 25'd0, 8'h01, 0,  1, 25'd0, 8'h01, 1, 0, 25'd1, 8'h01);
        tbl[2]  = mkv(1, 1, 8'd0, 25'd1, 8'h02, 0,  1, 25'd1, 8'h02, 1, 0, 25'd2, 8'h03);
        tbl[3]  = mkv(1, 0, 8'd0, 25'd1, 8'h02, 0,  0, 25'd0, 8'h00, 1, 0, 25'd2, 8'h03);
        tbl[4]  = mkv(1, 1, 8'd0, 25'd2, 8'hFF, 0,  1, 25'd2, 8'hFF, 1, 0, 25'd3, 8'h02);
        tbl[5]  = mkv(0, 0, 8'd0, 25'd0, 8'h00, 0,  0, 25'd0, 8'h00, 1, 0, 25'd3, 8'h02);
        tbl[6]  = mkv(0, 0, 8'd0, 25'd0, 8'h00, 0,  0, 25'd0, 8'h00, 1, 0, 25'd3, 8'h02);
        tbl[7]  = mkv(0, 0, 8'd0, 25'd0, 8'h00, 0,  0, 25'd0, 8'h00, 1, 0, 25'd3, 8'h02);
        tbl[8]  = mkv(0, 0, 8'd0, 25'd0, 8'h00, 0,  0, 25'd0, 8'h00, 1, 0, 25'd3, 8'h02);
        tbl[9]  = mkv(0, 0, 8'd0, 25'd0, 8'h00, 0,  0, 25'd0, 8'h00, 0, 1, 25'd3, 8'h02);
        tbl[10] = mkv(0, 0, 8'd0, 25'd0, 8'h00, 0,  0, 25'd0, 8'h00, 0, 0, 25'd3, 8'h02);
        tbl[11] = mkv(0, 0, 8'd0, 25'd0, 8'h00, 0,  0, 25'd0, 8'h00, 0, 0, 25'd3, 8'h02);

        #2 reset_n = 1'b0;
        #1;
        chk("reset values", {rom_we, core_reset, load_done, rom_addr, rom_data, sysmode, rom_bytes, rom_csum},
            {1'b0, 1'b1, 1'b0, 25'd0, 8'h00, 8'h00, 25'd0, 8'h00});
        chk("reset dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();

        // ROM download 01,02,FF then release after the hold window
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].dl, tbl[i].wr, tbl[i].idx, tbl[i].addr, tbl[i].dout);
            user_reset = tbl[i].ur;
            tick();
            ecs = CSUM_EN ? tbl[i].e_csum : 8'h00;
            checks++;
            if ({rom_we, core_reset, load_done, rom_bytes, rom_csum} !==
                {tbl[i].e_we, tbl[i].e_cr, tbl[i].e_done, tbl[i].e_bytes, ecs}) begin
                failures++;
                $display("FAIL table row %0d got we=%b cr=%b done=%b bytes=%0d csum=%h exp we=%b cr=%b done=%b bytes=%0d csum=%h",
                         i, rom_we, core_reset, load_done, rom_bytes, rom_csum,
                         tbl[i].e_we, tbl[i].e_cr, tbl[i].e_done, tbl[i].e_bytes, ecs);
            end
            if (tbl[i].e_we) chk($sformatf("table row %0d addr/data", i), {rom_addr, rom_data}, {tbl[i].e_addr, tbl[i].e_data});
        end

        // DIP writes while running
        set_in(1, 0, 8'd254, 25'd0, 8'h00); tick();
        set_in(1, 1, 8'd254, 25'd3, 8'hA5); tick();
        chk("dsw bank3", dsw, 64'hFFFF_FFFF_A5FF_FFFF);
        set_in(1, 1, 8'd254, 25'd8, 8'h5A); tick();
        chk("dsw addr8 ignored", dsw, 64'hFFFF_FFFF_A5FF_FFFF);
        set_in(0, 0, 8'd0, 25'd0, 8'h00); tick();
        chk("dsw no core reset", {core_reset, load_done}, 2'b00);

        // SYSMODE writes
        set_in(1, 0, 8'd1, 25'd0, 8'h00); tick();
        set_in(1, 1, 8'd1, 25'd0, 8'h06); tick();
        chk("sysmode addr0", sysmode, 8'h06);
        set_in(1, 1, 8'd1, 25'd1, 8'h07); tick();
        chk("sysmode addr1 ignored", sysmode, 8'h06);
        set_in(0, 0, 8'd0, 25'd0, 8'h00); tick();
        chk("sysmode no core reset", {core_reset, load_done}, 2'b00);

        // user_reset from RUN, then a re-request during HOLD
        user_reset = 1'b1; tick(); user_reset = 1'b0;
        chk("ureset asserts core_reset", core_reset, 1'b1);
        n = 1;
        while (core_reset && n < 50) begin tick(); n++; end
        chk("ureset release cycles", n, PH + 1);
        chk("ureset load_done", load_done, 1'b1);
        tick();
        chk("ureset load_done single", load_done, 1'b0);
        user_reset = 1'b1; tick(); user_reset = 1'b0;
        tick(); tick();
        user_reset = 1'b1; tick(); user_reset = 1'b0;
        n = 1;
        while (core_reset && n < 50) begin tick(); n++; end
        chk("ureset in hold reload", n, PH + 1);

        // Second download during HOLD abandons the first release
        set_in(1, 0, 8'd0, 25'd0, 8'h00); tick();
        for (int i = 0; i < 3; i++) begin set_in(1, 1, 8'd0, 25'(i), 8'(i + 1)); tick(); end
        set_in(0, 0, 8'd0, 25'd0, 8'h00); tick();
        done_seen = 0;
        tick(); tick();
        set_in(1, 1, 8'd0, 25'd0, 8'h11); tick();
        chk("restart coincident write bytes", rom_bytes, 25'd1);
        set_in(1, 1, 8'd0, 25'd1, 8'h22); tick();
        chk("restart bytes", rom_bytes, 25'd2);
        set_in(1, 0, 8'd0, 25'd1, 8'h00);
        for (int i = 0; i < 8; i++) tick();
        chk("restart no early release", {core_reset, 25'(done_seen)}, {1'b1, 25'd0});
        set_in(0, 0, 8'd0, 25'd0, 8'h00); tick();
        n = 1;
        while (core_reset && n < 50) begin tick(); n++; end
        chk("restart release cycles", n, PH + 1);
        chk("restart single load_done", done_seen, 1);

        // Reset in the middle of a ROM download
        set_in(1, 0, 8'd0, 25'd0, 8'h00); tick();
        for (int i = 0; i < 10; i++) begin set_in(1, 1, 8'd0, 25'(i), 8'($urandom)); tick(); end
        chk("mid-load bytes", rom_bytes, 25'd10);
        reset_n = 1'b0;
        #1;
        chk("async reset outputs", {rom_we, core_reset, load_done, sysmode, rom_bytes, rom_csum},
            {1'b0, 1'b1, 1'b0, 8'h00, 25'd0, 8'h00});
        chk("async reset dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
        set_in(0, 0, 8'd0, 25'd0, 8'h00);
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
        done_seen = 0;
        user_reset = 1'b1; tick(); user_reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("after reset stays idle", {core_reset, rom_bytes, 25'(done_seen)}, {1'b1, 25'd0, 25'd0});

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                ioctl_download = !ioctl_download;
                if (ioctl_download) ioctl_index = pick_idx();
            end
            if ($urandom_range(0, 63) == 0) ioctl_index = pick_idx();
            ioctl_wr   = ioctl_download ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            ioctl_addr = ($urandom_range(0, 7) == 0) ? 25'($urandom) : 25'($urandom_range(0, 11));
            ioctl_dout = 8'($urandom);
            user_reset = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
